ofdm_symbol_packer: RTL and testbench
=====================================

Name: ofdm_symbol_packer

Overview:
- Upstream feeder for the OFDM IFFT/AWGN/FFT chain.
- Accepts a stream of complex 32-bit float samples, one per cycle, under a valid/ready handshake.
- Packs each group of N samples into the flat N*W-bit real and imag frame buses consumed as input_real/input_imag.
- Double-buffered: the next symbol fills while the current one is held stable for the transform stage. A symbol is released only on the downstream acknowledge (done_state).

Parameters:
- N, 64: samples per OFDM symbol; must be a power of 2, minimum 4.
- W, 32: bits per real or imag sample (IEEE-754 single).
- LOGN, 6: log2(N), width of the sample index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present on in_real/in_imag.
- in_ready  out  1  packer can accept a sample this cycle.
- in_real  in  W  real part of the sample.
- in_imag  in  W  imag part of the sample.
- frame_real  out  N*W  packed real frame; sample k at [W*k +: W].
- frame_imag  out  N*W  packed imag frame; same layout as frame_real.
- frame_valid  out  1  output bank holds a complete symbol; drives the transform stage's busy_in.
- start  out  1  one-cycle pulse when a new symbol is first presented.
- frame_ack  in  1  downstream consumed the presented symbol (done_state); frees the output bank.
- frame_count  out  8  symbols presented since reset; wraps 255->0.
- overrun  out  1  sticky flag: in_valid asserted while in_ready=0.

Behaviour:
- Reset (async, active-low): clears all state regardless of activity; any in-flight partial symbol is discarded.
  - fill index 0, both banks empty.
  - frame_valid=0, start=0, frame_count=0, overrun=0.
  - frame_real/frame_imag=0.
  - in_ready=1 on the first cycle after reset release.
- Transfer: a sample is accepted when in_valid&&in_ready at a rising edge. It is written into the fill bank at index idx; idx increments, wrapping (N-1)->0.
- Fill bank states:
  - FILLING: idx<N or last sample not yet accepted.
  - FULL: all N samples present, waiting for the output bank.
- Output bank states:
  - EMPTY: frame_valid=0.
  - HELD: frame_valid=1, buses stable.
- Swap: fill bank FULL and output bank EMPTY -> copy fill to output on the next edge.
  - frame_valid rises, start pulses 1 cycle, frame_count increments.
  - Fill bank returns to FILLING with idx=0.
  - Latency: last sample accepted at edge t -> frame_valid/start high after edge t+1.
- in_ready = (fill bank FILLING) || (fill bank FULL && swap occurs this cycle). It is combinational from registered state only, not from in_valid.
- frame_ack while HELD: output bank goes EMPTY on the next edge. frame_ack while EMPTY is ignored.
- Simultaneous frame_ack and fill FULL: the swap happens on the same edge. frame_valid stays 1 with no bubble, start pulses again for the new symbol, and frame_real/frame_imag update on that edge.
- Output buses change only on a swap edge; they hold their value after ack until the next swap.
- Back-pressure: fill FULL and output HELD -> in_ready=0. If in_valid is high in that state, overrun is set and stays set until reset. The sample is not accepted.
- No arithmetic on sample data: bits pass through unmodified.

Optional Feature:
- Macro: OFDM_PACKER_BITREV_EN.
- Defined: sample with sequence number k is written at slot bitrev_LOGN(k), giving a bit-reversed input frame for a DIT transform. Handshake and timing are unchanged.
- Undefined: sample k is written at slot k (natural order).

Test Plan:
- Reset release, stream 64 samples real=k, imag=0x3F800000, frame_ack low -> one cycle after the 64th accept: frame_valid=1, start=1 for exactly 1 cycle, frame_real[32*k+:32]=k for all k, frame_count=1.
- Continue streaming 70 more samples, no ack -> 64 accepted, in_ready=0 from the 129th sample onward, overrun=1, frame_real unchanged.
- In the previous state, pulse frame_ack for 1 cycle -> swap on that edge, frame_valid stays 1, start pulses, frame_real holds the second symbol, frame_count=2, in_ready=1 the next cycle.
- frame_ack on the same cycle the 64th sample of symbol 3 is accepted while HELD -> no frame_valid low cycle, start pulses once, frame_count=3.
- Assert reset low after 30 samples of a symbol -> all outputs 0 immediately. After release, 64 new samples form a clean frame with no residue of the old 30.
- With OFDM_PACKER_BITREV_EN defined, stream samples real=k -> frame_real[32*1+:32]=32, frame_real[32*32+:32]=1, frame_real[32*63+:32]=63.

Source files
------------

// File: rtl/ofdm_symbol_packer.sv
// Double-buffered packer: gathers N complex samples into flat frame buses for the transform stage.
// Optional macro OFDM_PACKER_BITREV_EN writes sample k at slot bitrev(k) instead of slot k.
module ofdm_symbol_packer #(
    parameter int N    = 64,
    parameter int W    = 32,
    parameter int LOGN = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_real,
    input  logic [W-1:0]     in_imag,
    output logic [N*W-1:0]   frame_real,
    output logic [N*W-1:0]   frame_imag,
    output logic             frame_valid,
    output logic             start,
    input  logic             frame_ack,
    output logic [7:0]       frame_count,
    output logic             overrun
);

    typedef enum logic {FILLING, FULL} fill_state_t;
    // ACKED: acknowledged together with the last sample of the next symbol;
    // the bank stays presented for the single cycle until that symbol swaps in.
    typedef enum logic [1:0] {EMPTY, HELD, ACKED} out_state_t;

    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    fill_state_t     fill_state, fill_next;
    out_state_t      out_state, out_next;
    logic [LOGN-1:0] idx;
    logic [LOGN-1:0] wr_slot;
    logic            accept;
    logic            last_accept;
    logic            swap;
    logic [W-1:0]    fill_real [N];
    logic [W-1:0]    fill_imag [N];

`ifdef OFDM_PACKER_BITREV_EN
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) begin
            r[b] = v[LOGN-1-b];
        end
        return r;
    endfunction

    assign wr_slot = bitrev(idx);
`else
    assign wr_slot = idx;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_state <= FILLING;
            out_state  <= EMPTY;
        end else begin
            fill_state <= fill_next;
            out_state  <= out_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        fill_next = fill_state;
        out_next  = out_state;
        if (fill_state == FILLING && last_accept) begin
            fill_next = FULL;
        end else if (fill_state == FULL && swap) begin
            fill_next = FILLING;
        end
        if (swap) begin
            out_next = HELD;
        end else if (out_state == HELD && frame_ack) begin
            out_next = last_accept ? ACKED : EMPTY;
        end
    end

    // Output / handshake decode; none of it depends on in_valid
    always_comb begin
        swap        = 1'b0;
        in_ready    = 1'b0;
        frame_valid = 1'b0;
        if (fill_state == FULL && (out_state != HELD || frame_ack)) begin
            swap = 1'b1;
        end
        in_ready    = (fill_state == FILLING) || swap;
        frame_valid = (out_state != EMPTY);
    end

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (idx == LAST_IDX);

    // NOTE: the fill bank is storage only; it carries no reset because every slot
    // is rewritten before a symbol can be presented, so old contents never escape.
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_real[wr_slot] <= in_real;
            fill_imag[wr_slot] <= in_imag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            frame_real  <= '0;
            frame_imag  <= '0;
            start       <= 1'b0;
            frame_count <= 8'd0;
            overrun     <= 1'b0;
        end else begin
            start <= swap;
            if (accept) begin
                idx <= idx + 1'b1;
            end
            if (swap) begin
                for (int k = 0; k < N; k++) begin
                    frame_real[W*k +: W] <= fill_real[k];
                    frame_imag[W*k +: W] <= fill_imag[k];
                end
                frame_count <= frame_count + 8'd1;
            end
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_packer.sv
// Directed bench for ofdm_symbol_packer: fill/swap latency, back-pressure, ack-with-last-sample,
// mid-symbol reset and slot ordering (natural, or bit-reversed under OFDM_PACKER_BITREV_EN).
module tb_ofdm_symbol_packer;

    localparam int N = 64;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_real;
    logic [W-1:0]     in_imag;
    logic [N*W-1:0]   frame_real;
    logic [N*W-1:0]   frame_imag;
    logic             frame_valid;
    logic             start;
    logic             frame_ack;
    logic [7:0]       frame_count;
    logic             overrun;

    int n_compared   = 0;
    int n_mismatched = 0;

    ofdm_symbol_packer #(.N(N), .W(W), .LOGN(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .frame_real  (frame_real),
        .frame_imag  (frame_imag),
        .frame_valid (frame_valid),
        .start       (start),
        .frame_ack   (frame_ack),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slot that holds the sample with sequence number k (an involution either way)
    function automatic int slot_of(input int k);
`ifdef OFDM_PACKER_BITREV_EN
        int r = 0;
        for (int b = 0; b < 6; b++) begin
            if (k[b]) r = r | (1 << (5 - b));
        end
        return r;
`else
        return k;
`endif
    endfunction

    // Symbol sample k carries real = rbase + k, imag = ibase + (istep ? k : 0)
    task automatic check_frame(input string tag, input logic [31:0] rbase,
                               input logic [31:0] ibase, input bit istep);
        int bad = 0;
        for (int s = 0; s < N; s++) begin
            logic [31:0] er = rbase + slot_of(s);
            logic [31:0] ei = istep ? ibase + slot_of(s) : ibase;
            if (frame_real[W*s +: W] !== er || frame_imag[W*s +: W] !== ei) bad++;
        end
        check({tag, "_slot1"},  frame_real[W*1  +: W], rbase + slot_of(1));
        check({tag, "_slot32"}, frame_real[W*32 +: W], rbase + slot_of(32));
        check({tag, "_slot63"}, frame_real[W*63 +: W], rbase + slot_of(63));
        check({tag, "_bad_slots"}, bad, 0);
    endtask

    // Offer one sample for one cycle; ok reports whether it was accepted
    task automatic send(input logic [31:0] re, input logic [31:0] im, input bit ack, output bit ok);
        in_valid  = 1'b1;
        in_real   = re;
        in_imag   = im;
        frame_ack = ack;
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int accepted;
        int first_refused;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        frame_ack = 1'b0;

        #12;
        check("rst_frame_valid", frame_valid, 0);
        check("rst_start", start, 0);
        check("rst_count", frame_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_zero", (|frame_real) | (|frame_imag), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);

        // Symbol 1: real=k, imag=1.0f
        accepted = 0;
        for (int k = 0; k < N; k++) begin
            send(k, 32'h3F80_0000, 1'b0, ok);
            if (ok) accepted++;
        end
        check("s1_accepted", accepted, N);
        check("s1_valid_before_swap", frame_valid, 0);
        tick();
        check("s1_frame_valid", frame_valid, 1);
        check("s1_start", start, 1);
        check("s1_count", frame_count, 1);
        check_frame("s1", 32'd0, 32'h3F80_0000, 1'b0);
        tick();
        check("s1_start_one_cycle", start, 0);
        check("s1_overrun_clear", overrun, 0);

        // Symbol 2 streamed with no ack: 64 accepted, then back-pressure
        accepted = 0;
        first_refused = -1;
        for (int k = 0; k < 70; k++) begin
            send(32'h100 + k, 32'h4000_0000 + k, 1'b0, ok);
            if (ok) accepted++;
            else if (first_refused < 0) first_refused = k;
        end
        check("bp_accepted", accepted, 64);
        check("bp_first_refused", first_refused, 64);
        check("bp_in_ready", in_ready, 0);
        check("bp_overrun", overrun, 1);
        check("bp_count", frame_count, 1);
        check_frame("bp_hold", 32'd0, 32'h3F80_0000, 1'b0);

        // Ack while fill is full: swap on the ack edge, no bubble
        frame_ack = 1'b1;
        #1;
        check("ack_in_ready_swap", in_ready, 1);
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        check("ack_frame_valid", frame_valid, 1);
        check("ack_start", start, 1);
        check("ack_count", frame_count, 2);
        check_frame("s2", 32'h100, 32'h4000_0000, 1'b1);
        check("ack_in_ready_next", in_ready, 1);
        tick();
        check("ack_start_one_cycle", start, 0);

        // Symbol 3: ack lands together with the last sample
        accepted = 0;
        for (int k = 0; k < N; k++) begin
            send(32'h200 + k, 32'h4100_0000 + k, (k == N - 1), ok);
            if (ok) accepted++;
        end
        check("s3_accepted", accepted, N);
        check("s3_valid_no_bubble", frame_valid, 1);
        check("s3_no_early_start", start, 0);
        tick();
        check("s3_frame_valid", frame_valid, 1);
        check("s3_start", start, 1);
        check("s3_count", frame_count, 3);
        check_frame("s3", 32'h200, 32'h4100_0000, 1'b1);
        tick();
        check("s3_start_one_cycle", start, 0);

        // Reset in the middle of a partial symbol
        for (int k = 0; k < 30; k++) begin
            send(32'h300 + k, 32'h4200_0000 + k, 1'b0, ok);
        end
        check("pre_rst_overrun_sticky", overrun, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_frame_valid", frame_valid, 0);
        check("mid_rst_count", frame_count, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_frame_zero", (|frame_real) | (|frame_imag), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        for (int k = 0; k < N; k++) begin
            send(32'hA00 + k, 32'h4300_0000 + k, 1'b0, ok);
        end
        tick();
        check("s5_start", start, 1);
        check("s5_count", frame_count, 1);
        check_frame("s5", 32'hA00, 32'h4300_0000, 1'b1);

        // Ack with nothing pending: bank empties, buses hold their value
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("empty_frame_valid", frame_valid, 0);
        check("empty_start", start, 0);
        check_frame("empty_hold", 32'hA00, 32'h4300_0000, 1'b1);

        // Ack while already empty is ignored
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("idle_ack_valid", frame_valid, 0);
        check("idle_ack_count", frame_count, 1);
        check("idle_ack_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
